// File: rtl/alu_commit_stage.sv
// Commit-side consumer of ALU results: buffers them in a small in-order FIFO and
// retires each one to a contended PRF write port, with a bypass view of the head.
module alu_commit_stage #(
  parameter int DEPTH  = 2,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       alu_to_valid,
  output logic                       cs_allowin,
  input  logic [3:0]                 in_rf_we,
  input  logic [PREG_W-1:0]          in_phy_dest,
  input  logic [DATA_W-1:0]          in_result,
  input  logic                       in_exception,
  output logic [3:0]                 prf_we,
  output logic [PREG_W-1:0]          prf_waddr,
  output logic [DATA_W-1:0]          prf_wdata,
  input  logic                       prf_wr_grant,
  output logic [PREG_W+DATA_W:0]     cs_bypass_bus,
  output logic                       complete_valid,
  output logic [PREG_W-1:0]          complete_preg,
  output logic                       complete_ex,
  output logic [31:0]                stall_cycles
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [3:0]        mem_we_q   [DEPTH];
  logic [PREG_W-1:0] mem_pd_q   [DEPTH];
  logic [DATA_W-1:0] mem_res_q  [DEPTH];
  logic              mem_ex_q   [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [31:0]       stall_q,  stall_d;

  logic              head_valid;
  logic              head_needs_wr;
  logic              push;
  logic              pop;
  logic [3:0]        head_we;
  logic [PREG_W-1:0] head_pd;
  logic [DATA_W-1:0] head_res;
  logic              head_ex;

  always_comb begin
    head_we  = mem_we_q[rd_ptr_q];
    head_pd  = mem_pd_q[rd_ptr_q];
    head_res = mem_res_q[rd_ptr_q];
    head_ex  = mem_ex_q[rd_ptr_q];

    cs_allowin    = (count_q != CNT_W'(DEPTH));
    head_valid    = (count_q != '0);
    head_needs_wr = head_valid & (|head_we) & ~head_ex;

    push = alu_to_valid & cs_allowin & ~flush;
    // Entries that do not write the PRF (no byte enables, or faulted) drain without a grant.
    pop  = head_valid & (prf_wr_grant | ~head_needs_wr) & ~flush;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    stall_d = stall_q;
    if (alu_to_valid && !cs_allowin && !flush && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_we_q[i]  <= '0;
        mem_pd_q[i]  <= '0;
        mem_res_q[i] <= '0;
        mem_ex_q[i]  <= 1'b0;
      end
    end else if (push) begin
      mem_we_q[wr_ptr_q]  <= in_rf_we;
      mem_pd_q[wr_ptr_q]  <= in_phy_dest;
      mem_res_q[wr_ptr_q] <= in_result;
      mem_ex_q[wr_ptr_q]  <= in_exception;
    end
  end

  // Head fields are gated so stale storage never leaks onto idle outputs.
  assign prf_we         = (head_needs_wr && !flush) ? head_we : 4'b0;
  assign prf_waddr      = head_needs_wr ? head_pd  : '0;
  assign prf_wdata      = head_needs_wr ? head_res : '0;
  assign cs_bypass_bus  = head_needs_wr ? {1'b1, head_pd, head_res} : '0;
  assign complete_valid = pop;
  assign complete_preg  = pop ? head_pd : '0;
  assign complete_ex    = pop & head_ex;
  assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_alu_commit_stage.sv
// Directed bench for alu_commit_stage: drives on the falling edge, checks 1ns later.
module tb_alu_commit_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        alu_to_valid;
  logic        cs_allowin;
  logic [3:0]  in_rf_we;
  logic [5:0]  in_phy_dest;
  logic [31:0] in_result;
  logic        in_exception;
  logic [3:0]  prf_we;
  logic [5:0]  prf_waddr;
  logic [31:0] prf_wdata;
  logic        prf_wr_grant;
  logic [38:0] cs_bypass_bus;
  logic        complete_valid;
  logic [5:0]  complete_preg;
  logic        complete_ex;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_commit_stage #(.DEPTH(2), .PREG_W(6), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .alu_to_valid(alu_to_valid),
    .cs_allowin(cs_allowin), .in_rf_we(in_rf_we), .in_phy_dest(in_phy_dest),
    .in_result(in_result), .in_exception(in_exception), .prf_we(prf_we),
    .prf_waddr(prf_waddr), .prf_wdata(prf_wdata), .prf_wr_grant(prf_wr_grant),
    .cs_bypass_bus(cs_bypass_bus), .complete_valid(complete_valid),
    .complete_preg(complete_preg), .complete_ex(complete_ex),
    .stall_cycles(stall_cycles)
  );

  task automatic drive(input logic v, input logic [3:0] we, input int pd,
                       input logic [31:0] res, input logic ex, input logic g,
                       input logic fl);
    alu_to_valid = v;
    in_rf_we     = we;
    in_phy_dest  = 6'(pd);
    in_result    = res;
    in_exception = ex;
    prf_wr_grant = g;
    flush        = fl;
  endtask

  task automatic idle(input logic g);
    drive(1'b0, 4'h0, 0, 32'h0, 1'b0, g, 1'b0);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    idle(1'b0);
    #3;
    n_checks++; if (cs_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got %b want 1", cs_allowin); end
    n_checks++; if (prf_we !== 4'h0) begin n_fail++; $display("FAIL reset_prf_we got %h want 0", prf_we); end
    n_checks++; if (cs_bypass_bus !== 39'h0) begin n_fail++; $display("FAIL reset_bypass got %h want 0", cs_bypass_bus); end
    n_checks++; if (complete_valid !== 1'b0) begin n_fail++; $display("FAIL reset_complete got %b want 0", complete_valid); end
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cycles); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk); drive(1'b1, 4'hF, 5, 32'h1234, 1'b0, 1'b1, 1'b0); #1;
    n_checks++; if (complete_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_passthru got %b want 0", complete_valid); end
    n_checks++; if (prf_we !== 4'h0) begin n_fail++; $display("FAIL single_no_passthru_we got %h want 0", prf_we); end
    @(negedge clk); idle(1'b1); #1;
    n_checks++; if (prf_we !== 4'hF) begin n_fail++; $display("FAIL single_prf_we got %h want f", prf_we); end
    n_checks++; if (prf_waddr !== 6'd5) begin n_fail++; $display("FAIL single_waddr got %0d want 5", prf_waddr); end
    n_checks++; if (prf_wdata !== 32'h1234) begin n_fail++; $display("FAIL single_wdata got %h want 1234", prf_wdata); end
    n_checks++; if (complete_valid !== 1'b1) begin n_fail++; $display("FAIL single_complete got %b want 1", complete_valid); end
    n_checks++; if (complete_ex !== 1'b0) begin n_fail++; $display("FAIL single_ex got %b want 0", complete_ex); end
    n_checks++; if (complete_preg !== 6'd5) begin n_fail++; $display("FAIL single_preg got %0d want 5", complete_preg); end
    n_checks++; if (cs_bypass_bus !== {1'b1, 6'd5, 32'h1234}) begin n_fail++; $display("FAIL single_bypass got %h want %h", cs_bypass_bus, {1'b1, 6'd5, 32'h1234}); end
    @(negedge clk); idle(1'b1); #1;
    n_checks++; if (complete_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got %b want 0", complete_valid); end
    n_checks++; if (cs_allowin !== 1'b1) begin n_fail++; $display("FAIL single_allowin got %b want 1", cs_allowin); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); drive(1'b1, 4'hF, 1, 32'h11, 1'b0, 1'b0, 1'b0); #1;
    n_checks++; if (cs_allowin !== 1'b1) begin n_fail++; $display("FAIL b2b_allow0 got %b want 1", cs_allowin); end
    @(negedge clk); drive(1'b1, 4'hF, 2, 32'h22, 1'b0, 1'b0, 1'b0); #1;
    n_checks++; if (cs_allowin !== 1'b1) begin n_fail++; $display("FAIL b2b_allow1 got %b want 1", cs_allowin); end
    n_checks++; if (complete_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_nogrant got %b want 0", complete_valid); end
    @(negedge clk); drive(1'b1, 4'hF, 3, 32'h33, 1'b0, 1'b0, 1'b0); #1;
    n_checks++; if (cs_allowin !== 1'b0) begin n_fail++; $display("FAIL b2b_full got %b want 0", cs_allowin); end
    n_checks++; if (prf_waddr !== 6'd1) begin n_fail++; $display("FAIL b2b_head_waddr got %0d want 1", prf_waddr); end
    n_checks++; if (cs_bypass_bus[38] !== 1'b1) begin n_fail++; $display("FAIL b2b_bypass_valid got %b want 1", cs_bypass_bus[38]); end
    @(negedge clk); #1;
    n_checks++; if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL b2b_stall1 got %0d want 1", stall_cycles); end
    @(negedge clk); prf_wr_grant = 1'b1; #1;
    n_checks++; if (cs_allowin !== 1'b0) begin n_fail++; $display("FAIL b2b_full_on_pop got %b want 0", cs_allowin); end
    n_checks++; if (stall_cycles !== 32'd2) begin n_fail++; $display("FAIL b2b_stall2 got %0d want 2", stall_cycles); end
    n_checks++; if (complete_valid !== 1'b1 || complete_preg !== 6'd1) begin n_fail++; $display("FAIL b2b_ret1 got %b/%0d want 1/1", complete_valid, complete_preg); end
    @(negedge clk); #1;
    n_checks++; if (cs_allowin !== 1'b1) begin n_fail++; $display("FAIL b2b_reopen got %b want 1", cs_allowin); end
    n_checks++; if (complete_valid !== 1'b1 || complete_preg !== 6'd2 || prf_wdata !== 32'h22) begin n_fail++; $display("FAIL b2b_ret2 got %b/%0d/%h want 1/2/22", complete_valid, complete_preg, prf_wdata); end
    @(negedge clk); idle(1'b1); #1;
    n_checks++; if (complete_valid !== 1'b1 || complete_preg !== 6'd3 || prf_wdata !== 32'h33) begin n_fail++; $display("FAIL b2b_ret3 got %b/%0d/%h want 1/3/33", complete_valid, complete_preg, prf_wdata); end
    @(negedge clk); idle(1'b1); #1;
    n_checks++; if (complete_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", complete_valid); end
    n_checks++; if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL b2b_stall3 got %0d want 3", stall_cycles); end
  endtask

  task automatic test_exception;
    @(negedge clk); drive(1'b1, 4'hF, 7, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    @(negedge clk); idle(1'b0); #1;
    n_checks++; if (prf_we !== 4'h0) begin n_fail++; $display("FAIL ex_prf_we got %h want 0", prf_we); end
    n_checks++; if (complete_valid !== 1'b1) begin n_fail++; $display("FAIL ex_complete got %b want 1", complete_valid); end
    n_checks++; if (complete_ex !== 1'b1) begin n_fail++; $display("FAIL ex_flag got %b want 1", complete_ex); end
    n_checks++; if (complete_preg !== 6'd7) begin n_fail++; $display("FAIL ex_preg got %0d want 7", complete_preg); end
    n_checks++; if (cs_bypass_bus[38] !== 1'b0) begin n_fail++; $display("FAIL ex_bypass_valid got %b want 0", cs_bypass_bus[38]); end
    @(negedge clk); drive(1'b1, 4'h0, 9, 32'h99, 1'b0, 1'b0, 1'b0);
    @(negedge clk); idle(1'b0); #1;
    n_checks++; if (complete_valid !== 1'b1 || complete_ex !== 1'b0 || complete_preg !== 6'd9) begin n_fail++; $display("FAIL nowe_retire got %b/%b/%0d want 1/0/9", complete_valid, complete_ex, complete_preg); end
    n_checks++; if (prf_we !== 4'h0) begin n_fail++; $display("FAIL nowe_prf_we got %h want 0", prf_we); end
    @(negedge clk); #1;
    n_checks++; if (complete_valid !== 1'b0) begin n_fail++; $display("FAIL ex_empty got %b want 0", complete_valid); end
  endtask

  task automatic test_flush;
    @(negedge clk); drive(1'b1, 4'hF, 11, 32'hB1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 4'hF, 12, 32'hB2, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 4'hF, 13, 32'hB3, 1'b0, 1'b1, 1'b1); #1;
    n_checks++; if (cs_allowin !== 1'b0) begin n_fail++; $display("FAIL flush_full got %b want 0", cs_allowin); end
    n_checks++; if (prf_we !== 4'h0) begin n_fail++; $display("FAIL flush_prf_we got %h want 0", prf_we); end
    n_checks++; if (complete_valid !== 1'b0) begin n_fail++; $display("FAIL flush_complete got %b want 0", complete_valid); end
    @(negedge clk); idle(1'b1); #1;
    n_checks++; if (cs_allowin !== 1'b1) begin n_fail++; $display("FAIL flush_allowin got %b want 1", cs_allowin); end
    n_checks++; if (prf_we !== 4'h0 || complete_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got %h/%b want 0/0", prf_we, complete_valid); end
    n_checks++; if (cs_bypass_bus !== 39'h0 || prf_waddr !== 6'd0) begin n_fail++; $display("FAIL flush_outputs got %h/%0d want 0/0", cs_bypass_bus, prf_waddr); end
    n_checks++; if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL flush_stall got %0d want 3", stall_cycles); end
  endtask

  task automatic test_async_reset;
    @(negedge clk); drive(1'b1, 4'hF, 20, 32'hC0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); idle(1'b0); #1;
    n_checks++; if (prf_we !== 4'hF) begin n_fail++; $display("FAIL arst_pre got %h want f", prf_we); end
    #1 resetn = 1'b0;
    #1;
    n_checks++; if (prf_we !== 4'h0 || cs_bypass_bus !== 39'h0) begin n_fail++; $display("FAIL arst_outputs got %h/%h want 0/0", prf_we, cs_bypass_bus); end
    n_checks++; if (cs_allowin !== 1'b1) begin n_fail++; $display("FAIL arst_allowin got %b want 1", cs_allowin); end
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL arst_stall got %0d want 0", stall_cycles); end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); drive(1'b1, 4'hF, 21, 32'h55, 1'b0, 1'b1, 1'b0);
    @(negedge clk); idle(1'b1); #1;
    n_checks++; if (complete_valid !== 1'b1 || complete_preg !== 6'd21 || prf_wdata !== 32'h55) begin n_fail++; $display("FAIL arst_retire got %b/%0d/%h want 1/21/55", complete_valid, complete_preg, prf_wdata); end
  endtask

  task automatic test_wrap;
    int q[$];
    int next_i = 0;
    int done   = 0;
    int cyc    = 0;
    logic g, v, exp_allow, exp_cv;
    while (done < 6 && cyc < 100) begin
      @(negedge clk);
      g = cyc[0];
      v = (next_i < 6);
      drive(v, 4'hF, 30 + next_i, 32'hA000_0000 + 32'(next_i), 1'b0, g, 1'b0);
      #1;
      exp_allow = (q.size() != 2);
      exp_cv    = (q.size() > 0) && g;
      n_checks++; if (cs_allowin !== exp_allow) begin n_fail++; $display("FAIL wrap_allowin cyc %0d got %b want %b", cyc, cs_allowin, exp_allow); end
      n_checks++; if (complete_valid !== exp_cv) begin n_fail++; $display("FAIL wrap_complete cyc %0d got %b want %b", cyc, complete_valid, exp_cv); end
      if (exp_cv) begin
        n_checks++; if (complete_preg !== 6'(30 + q[0]) || prf_wdata !== 32'hA000_0000 + 32'(q[0])) begin n_fail++; $display("FAIL wrap_order cyc %0d got %0d/%h want %0d/%h", cyc, complete_preg, prf_wdata, 30 + q[0], 32'hA000_0000 + 32'(q[0])); end
        void'(q.pop_front());
        done++;
      end
      if (v && exp_allow) begin
        q.push_back(next_i);
        next_i++;
      end
      cyc++;
    end
    n_checks++; if (done != 6) begin n_fail++; $display("FAIL wrap_timeout retired %0d want 6", done); end
    @(negedge clk); idle(1'b1); #1;
    n_checks++; if (complete_valid !== 1'b0 || cs_allowin !== 1'b1) begin n_fail++; $display("FAIL wrap_drained got %b/%b want 0/1", complete_valid, cs_allowin); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_exception();
    test_flush();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
